ulpi_reg_sequencer: RTL and testbench

Queued ULPI register-access engine, the parametrised successor of the single-shot ULPI link controller. It accepts register read/write commands through a valid/ready port into a DEPTH-entry FIFO and executes them on the ULPI bus. Each command gets exactly one tagged response. The engine supports extended (8-bit) register addressing, automatic retry when the PHY aborts with DIR, and a NXT-wait timeout. It also captures RX CMD bytes whenever the PHY owns the bus. It sits between the PHY pins and the configuration/audio control logic; packet data transfer is out of scope.

---
 rtl/ulpi_pkg.sv | 49 ++++
 rtl/ulpi_cmd_fifo.sv | 51 +++++
 rtl/ulpi_reg_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_ulpi_reg_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// Shared types and constants for the queued ULPI register-access engine:
// FSM encoding, TXCMD prefixes, response codes and the command record.
package ulpi_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_WAIT_PHY = 4'd1,
    ST_IDLE     = 4'd2,
    ST_TXCMD    = 4'd3,
    ST_EXTADR   = 4'd4,
    ST_WDATA    = 4'd5,
    ST_STOP     = 4'd6,
    ST_RD_TURN  = 4'd7,
    ST_RD_DATA  = 4'd8,
    ST_RX       = 4'd9,
    ST_RX_TURN  = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_ABORTED = 2'd1,
    STAT_TIMEOUT = 2'd2
  } status_e;

  localparam logic [1:0] TXCMD_WR      = 2'b10;
  localparam logic [1:0] TXCMD_RD      = 2'b11;
  localparam logic [5:0] EXT_ADDR_CODE = 6'h2F;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] tag;
  } cmd_t;

  function automatic logic use_ext(input cmd_t c, input logic ext_en);
    return ext_en && (c.addr >= 8'h2F);
  endfunction

  // Addresses at or above the extended code are sent as 0x2F plus a follow-up byte.
  function automatic logic [7:0] txcmd_byte(input cmd_t c, input logic ext_en);
    logic [1:0] pre;
    logic [5:0] fld;
    pre = c.rw ? TXCMD_WR : TXCMD_RD;
    fld = use_ext(c, ext_en) ? EXT_ADDR_CODE : c.addr[5:0];
    return {pre, fld};
  endfunction

endpackage

// File: rtl/ulpi_cmd_fifo.sv
// Synchronous FIFO of command records; head is visible without popping so a
// retried command can be reloaded until its response retires it.
module ulpi_cmd_fifo
  import ulpi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  cmd_t push_data_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  cmd_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_sequencer.sv
// Queued ULPI register read/write engine with extended addressing, DIR-abort
// retry, NXT timeout and RX CMD capture. Outputs are registered from next state.
module ulpi_reg_sequencer
  import ulpi_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255,
  parameter int EXT_ADDR  = 1
) (
  input  logic       CLK_60M,
  input  logic       RST_USB,
  input  logic [7:0] USB_DATA_I,
  output logic [7:0] USB_DATA_O,
  output logic       USB_DATA_OE,
  input  logic       USB_DIR,
  input  logic       USB_NXT,
  output logic       USB_STP,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_RW,
  input  logic [7:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  input  logic [3:0] CMD_TAG,
  output logic       RSP_VALID,
  output logic [3:0] RSP_TAG,
  output logic [7:0] RSP_RDATA,
  output logic [1:0] RSP_STATUS,
  output logic [7:0] RXCMD,
  output logic       RXCMD_STRB,
  output logic       BUSY
);

  localparam logic EXT_EN = (EXT_ADDR != 0);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  cmd_t               cur_q, cur_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               dir_q;
  logic               run_q;
  logic [7:0]         data_q, data_d;
  logic               stp_q, stp_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [3:0]         rsp_tag_q, rsp_tag_d;
  logic [7:0]         rsp_rdata_q, rsp_rdata_d;
  status_e            rsp_status_q, rsp_status_d;
  logic [7:0]         rxcmd_q, rxcmd_d;
  logic               rxcmd_strb_q, rxcmd_strb_d;

  logic    abort_s, done_s, rd_capture_s, rsp_fire_s;
  status_e done_status_s, rsp_status_s;
  logic    push_s, fifo_full_s, fifo_empty_s;
  cmd_t    cmd_in_s, fifo_head_s;

  assign cmd_in_s = '{rw: CMD_RW, addr: CMD_ADDR, wdata: CMD_WDATA, tag: CMD_TAG};
  assign push_s   = CMD_VALID && CMD_READY;

  ulpi_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (CLK_60M),
    .rst_i       (RST_USB),
    .push_i      (push_s),
    .push_data_i (cmd_in_s),
    .pop_i       (rsp_valid_q),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  assign rsp_fire_s   = done_s || (abort_s && (retry_q == RETRY_MAX));
  assign rsp_status_s = abort_s ? STAT_ABORTED : done_status_s;

  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      state_q      <= ST_RESET;
      cur_q        <= '0;
      retry_q      <= '0;
      wait_q       <= '0;
      dir_q        <= 1'b1;
      run_q        <= 1'b0;
      data_q       <= 8'h00;
      stp_q        <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_tag_q    <= 4'h0;
      rsp_rdata_q  <= 8'h00;
      rsp_status_q <= STAT_OK;
      rxcmd_q      <= 8'h00;
      rxcmd_strb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      retry_q      <= retry_d;
      wait_q       <= wait_d;
      dir_q        <= USB_DIR;
      run_q        <= 1'b1;
      data_q       <= data_d;
      stp_q        <= stp_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      rxcmd_q      <= rxcmd_d;
      rxcmd_strb_q <= rxcmd_strb_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    wait_d        = '0;
    abort_s       = 1'b0;
    done_s        = 1'b0;
    done_status_s = STAT_OK;
    rd_capture_s  = 1'b0;
    case (state_q)
      ST_RESET:    state_d = ST_WAIT_PHY;
      ST_WAIT_PHY: state_d = USB_DIR ? ST_WAIT_PHY : ST_IDLE;
      ST_IDLE: begin
        if (USB_DIR) begin
          state_d = ST_RX;
        end else if (!fifo_empty_s) begin
          state_d = ST_TXCMD;
          cur_d   = fifo_head_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TXCMD: begin
        if (USB_DIR) begin
          state_d = ST_RX;
          abort_s = 1'b1;
        end else if (USB_NXT) begin
          if (use_ext(cur_q, EXT_EN)) begin
            state_d = ST_EXTADR;
          end else begin
            state_d = cur_q.rw ? ST_WDATA : ST_RD_TURN;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d       = ST_STOP;
          done_s        = 1'b1;
          done_status_s = STAT_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_EXTADR: begin
        if (USB_DIR) begin
          state_d = ST_RX;
          abort_s = 1'b1;
        end else if (USB_NXT) begin
          state_d = cur_q.rw ? ST_WDATA : ST_RD_TURN;
        end else begin
          state_d = ST_EXTADR;
        end
      end
      ST_WDATA: begin
        if (USB_DIR) begin
          state_d = ST_RX;
          abort_s = 1'b1;
        end else if (USB_NXT) begin
          state_d = ST_STOP;
          done_s  = 1'b1;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_STOP:    state_d = ST_IDLE;
      ST_RD_TURN: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (USB_NXT) begin
          state_d = ST_RX;
          abort_s = 1'b1;
        end else if (USB_DIR) begin
          state_d      = ST_RX_TURN;
          done_s       = 1'b1;
          rd_capture_s = 1'b1;
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RX:      state_d = USB_DIR ? ST_RX : ST_RX_TURN;
      ST_RX_TURN: state_d = ST_IDLE;
      default:    state_d = ST_RESET;
    endcase
  end

  // Retry count survives aborts until the command is finally retired.
  always_comb begin
    if (rsp_fire_s) begin
      retry_d = '0;
    end else if (abort_s) begin
      retry_d = retry_q + 1'b1;
    end else begin
      retry_d = retry_q;
    end
  end

  always_comb begin
    data_d = 8'h00;
    stp_d  = 1'b0;
    case (state_d)
      ST_RESET, ST_WAIT_PHY, ST_STOP: stp_d = 1'b1;
      ST_TXCMD:  data_d = txcmd_byte(cur_d, EXT_EN);
      ST_EXTADR: data_d = cur_d.addr;
      ST_WDATA:  data_d = cur_d.wdata;
      default:   data_d = 8'h00;
    endcase
    rsp_valid_d = rsp_fire_s;
    if (rsp_fire_s) begin
      rsp_tag_d    = cur_q.tag;
      rsp_status_d = rsp_status_s;
      rsp_rdata_d  = rd_capture_s ? USB_DATA_I : 8'h00;
    end else begin
      rsp_tag_d    = 4'h0;
      rsp_status_d = STAT_OK;
      rsp_rdata_d  = 8'h00;
    end
    if ((state_q == ST_RX) && USB_DIR && dir_q && !USB_NXT) begin
      rxcmd_d      = USB_DATA_I;
      rxcmd_strb_d = 1'b1;
    end else begin
      rxcmd_d      = rxcmd_q;
      rxcmd_strb_d = 1'b0;
    end
  end

  assign USB_DATA_O  = data_q;
  assign USB_DATA_OE = run_q && !USB_DIR && !dir_q;
  assign USB_STP     = stp_q;
  assign CMD_READY   = run_q && !fifo_full_s;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_TAG     = rsp_tag_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_STATUS  = rsp_status_q;
  assign RXCMD       = rxcmd_q;
  assign RXCMD_STRB  = rxcmd_strb_q;
  assign BUSY        = !fifo_empty_s;

endmodule

// File: tb/tb_ulpi_reg_sequencer.sv
// Directed bench for ulpi_reg_sequencer: a hand-driven PHY on the negative edge
// with every expected bus byte and response written out by hand.
module tb_ulpi_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] usb_data_i = 8'h00;
  logic [7:0] usb_data_o;
  logic       usb_data_oe;
  logic       usb_dir = 1'b0;
  logic       usb_nxt = 1'b0;
  logic       usb_stp;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic [3:0] cmd_tag = 4'h0;
  logic       rsp_valid;
  logic [3:0] rsp_tag;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic [7:0] rxcmd;
  logic       rxcmd_strb;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ulpi_reg_sequencer #(.DEPTH(4), .MAX_RETRY(3), .TIMEOUT(255), .EXT_ADDR(1)) dut (
    .CLK_60M    (clk),
    .RST_USB    (rst),
    .USB_DATA_I (usb_data_i),
    .USB_DATA_O (usb_data_o),
    .USB_DATA_OE(usb_data_oe),
    .USB_DIR    (usb_dir),
    .USB_NXT    (usb_nxt),
    .USB_STP    (usb_stp),
    .CMD_VALID  (cmd_valid),
    .CMD_READY  (cmd_ready),
    .CMD_RW     (cmd_rw),
    .CMD_ADDR   (cmd_addr),
    .CMD_WDATA  (cmd_wdata),
    .CMD_TAG    (cmd_tag),
    .RSP_VALID  (rsp_valid),
    .RSP_TAG    (rsp_tag),
    .RSP_RDATA  (rsp_rdata),
    .RSP_STATUS (rsp_status),
    .RXCMD      (rxcmd),
    .RXCMD_STRB (rxcmd_strb),
    .BUSY       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic rw, input logic [7:0] addr, input logic [7:0] wd,
                      input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_tag   = tag;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] b);
    int n = 0;
    while (!(usb_data_o === b && usb_data_oe === 1'b1) && n < 400) begin
      step();
      n++;
    end
    check_eq(tag, usb_data_o, b);
  endtask

  task automatic check_rsp(input string tag, input logic [3:0] t, input logic [1:0] st,
                           input logic [7:0] rd);
    check_eq({tag, "_valid"}, rsp_valid, 1'b1);
    check_eq({tag, "_tag"}, rsp_tag, t);
    check_eq({tag, "_status"}, rsp_status, st);
    check_eq({tag, "_rdata"}, rsp_rdata, rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int got;
    int seen;

    // Reset values
    repeat (3) step();
    check_eq("rst_stp", usb_stp, 1'b1);
    check_eq("rst_data", usb_data_o, 8'h00);
    check_eq("rst_oe", usb_data_oe, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_ready", cmd_ready, 1'b0);
    check_eq("rst_rxcmd", rxcmd, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    n = 0;
    while (usb_stp !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check_eq("startup_stp", usb_stp, 1'b0);
    check_eq("startup_ready", cmd_ready, 1'b1);

    // Write 0x04 <- 0x45, NXT at first byte
    push(1'b1, 8'h04, 8'h45, 4'h1);
    step();
    check_eq("wr_txcmd", usb_data_o, 8'h84);
    check_eq("wr_txcmd_oe", usb_data_oe, 1'b1);
    usb_nxt = 1'b1;
    step();
    check_eq("wr_data", usb_data_o, 8'h45);
    check_eq("wr_data_no_rsp", rsp_valid, 1'b0);
    step();
    check_eq("wr_stp", usb_stp, 1'b1);
    check_eq("wr_stop_data", usb_data_o, 8'h00);
    check_rsp("wr_rsp", 4'h1, 2'd0, 8'h00);
    usb_nxt = 1'b0;
    step();
    check_eq("wr_rsp_pulse", rsp_valid, 1'b0);
    check_eq("wr_stp_low", usb_stp, 1'b0);

    // Read 0x0A, PHY returns 0x5A
    push(1'b0, 8'h0A, 8'h00, 4'h2);
    wait_byte("rd_txcmd", 8'hCA);
    usb_nxt = 1'b1;
    step();
    usb_dir = 1'b1;
    usb_nxt = 1'b0;
    #1;
    check_eq("rd_turn_oe", usb_data_oe, 1'b0);
    step();
    usb_data_i = 8'h5A;
    #1;
    check_eq("rd_data_oe", usb_data_oe, 1'b0);
    check_eq("rd_data_no_rsp", rsp_valid, 1'b0);
    step();
    check_rsp("rd_rsp", 4'h2, 2'd0, 8'h5A);
    usb_dir = 1'b0;
    usb_data_i = 8'h00;
    step();
    check_eq("rd_rsp_pulse", rsp_valid, 1'b0);

    // Extended write 0x80 <- 0x11
    push(1'b1, 8'h80, 8'h11, 4'h3);
    wait_byte("ext_txcmd", 8'hAF);
    usb_nxt = 1'b1;
    step();
    check_eq("ext_addr", usb_data_o, 8'h80);
    step();
    check_eq("ext_data", usb_data_o, 8'h11);
    step();
    check_eq("ext_stp", usb_stp, 1'b1);
    check_rsp("ext_rsp", 4'h3, 2'd0, 8'h00);
    usb_nxt = 1'b0;
    step();

    // DIR abort four times: three re-issues, then ABORTED
    push(1'b1, 8'h05, 8'h22, 4'h4);
    for (int i = 0; i < 4; i++) begin
      wait_byte("abort_txcmd", 8'h85);
      usb_dir = 1'b1;
      usb_nxt = 1'b0;
      usb_data_i = 8'h40 + 8'(i);
      step();
      check_eq("abort_rsp_valid", rsp_valid, (i == 3) ? 1'b1 : 1'b0);
      if (i == 3) begin
        check_eq("abort_status", rsp_status, 2'd1);
        check_eq("abort_tag", rsp_tag, 4'h4);
      end
      step();
      check_eq("abort_rx_strb", rxcmd_strb, 1'b1);
      check_eq("abort_rxcmd", rxcmd, 8'h40 + 8'(i));
      usb_dir = 1'b0;
      step();
      check_eq("abort_rx_strb_pulse", rxcmd_strb, 1'b0);
    end
    check_eq("abort_busy", busy, 1'b0);
    usb_data_i = 8'h00;

    // Timeout on NXT, then the queued command proceeds
    push(1'b1, 8'h06, 8'h55, 4'h5);
    push(1'b1, 8'h07, 8'h33, 4'h6);
    wait_byte("to_txcmd", 8'h86);
    n = 0;
    while (usb_stp !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check_eq("to_cycles", n, 255);
    check_rsp("to_rsp", 4'h5, 2'd2, 8'h00);
    step();
    check_eq("to_stp_one_cycle", usb_stp, 1'b0);
    check_eq("to_rsp_pulse", rsp_valid, 1'b0);
    wait_byte("to_next_txcmd", 8'h87);
    usb_nxt = 1'b1;
    step();
    check_eq("to_next_data", usb_data_o, 8'h33);
    step();
    check_rsp("to_next_rsp", 4'h6, 2'd0, 8'h00);
    usb_nxt = 1'b0;
    step();

    // FIFO stress with the PHY holding the bus
    usb_dir = 1'b1;
    usb_nxt = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("fifo_ready_before_push", cmd_ready, 1'b1);
      push(1'b1, 8'h10 + 8'(i), 8'hA0 + 8'(i), 4'(i));
    end
    check_eq("fifo_full_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1;
    cmd_tag = 4'h4;
    step();
    check_eq("fifo_fifth_ready", cmd_ready, 1'b0);
    check_eq("fifo_busy", busy, 1'b1);
    cmd_valid = 1'b0;
    usb_dir = 1'b0;
    got = 0;
    n = 0;
    while (got < 4 && n < 200) begin
      step();
      n++;
      if (rsp_valid === 1'b1) begin
        check_eq("fifo_rsp_tag", rsp_tag, got);
        check_eq("fifo_rsp_status", rsp_status, 2'd0);
        got++;
      end
    end
    check_eq("fifo_rsp_count", got, 4);
    step();
    check_eq("fifo_drained_busy", busy, 1'b0);
    check_eq("fifo_drained_ready", cmd_ready, 1'b1);

    // Reset in the middle of a write
    usb_nxt = 1'b0;
    push(1'b1, 8'h08, 8'h77, 4'h9);
    wait_byte("mid_rst_txcmd", 8'h88);
    rst = 1'b1;
    step();
    check_eq("mid_rst_stp", usb_stp, 1'b1);
    check_eq("mid_rst_oe", usb_data_oe, 1'b0);
    check_eq("mid_rst_data", usb_data_o, 8'h00);
    check_eq("mid_rst_rsp", rsp_valid, 1'b0);
    check_eq("mid_rst_ready", cmd_ready, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid === 1'b1) begin
        seen++;
      end
    end
    check_eq("mid_rst_no_rsp", seen, 0);
    check_eq("mid_rst_restart_stp", usb_stp, 1'b0);
    check_eq("mid_rst_restart_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
